// File: rtl/l1_cache_ctrl.sv
// l1_cache_ctrl: direct-mapped, write-back, write-allocate L1 controller with
// one word per line, I/S/M line states and snoop-invalidate support. Misses
// issue at most one memory transaction at a time toward the shared memory.
//
// state  | meaning
// IDLE   | ready for a CPU request
// LOOKUP | tag compare, hit service, miss classification
// WB     | writing back the dirty victim, waiting for processor_resp
// GAP    | one idle bus cycle between writeback and fill
// FILL   | reading the requested word, waiting for processor_resp
// RESP   | one-cycle completion pulse to the CPU
module l1_cache_ctrl #(
  parameter int DATA_SIZE = 2,
  parameter int ADDR_W    = 14,
  parameter int NUM_LINES = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cpu_req_valid,
  output logic                   cpu_req_ready,
  input  logic                   cpu_we,
  input  logic [ADDR_W-1:0]      cpu_addr,
  input  logic [DATA_SIZE*8-1:0] cpu_wdata,
  output logic [DATA_SIZE*8-1:0] cpu_rdata,
  output logic                   cpu_resp_valid,
  output logic                   processor_req,
  output logic                   mem_read_req,
  output logic                   mem_write_req,
  output logic [ADDR_W-1:0]      addr,
  output logic [DATA_SIZE*8-1:0] mem_write_data,
  input  logic [DATA_SIZE*8-1:0] mem_read_data,
  input  logic                   processor_resp,
  input  logic                   snoop_inv,
  input  logic [ADDR_W-1:0]      snoop_addr,
  output logic [15:0]            hit_count,
  output logic [15:0]            miss_count
);

  localparam int DW    = DATA_SIZE * 8;
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - IDX_W;

  localparam logic [1:0] L_I = 2'd0;
  localparam logic [1:0] L_S = 2'd1;
  localparam logic [1:0] L_M = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WB, S_GAP, S_FILL, S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              req_we_q, req_we_d;
  logic [DW-1:0]     req_wdata_q, req_wdata_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic [15:0]       hit_count_q, hit_count_d;
  logic [15:0]       miss_count_q, miss_count_d;

  logic [TAG_W-1:0]  tag_q  [NUM_LINES];
  logic [TAG_W-1:0]  tag_d  [NUM_LINES];
  logic [DW-1:0]     data_q [NUM_LINES];
  logic [DW-1:0]     data_d [NUM_LINES];
  logic [1:0]        lst_q  [NUM_LINES];
  logic [1:0]        lst_d  [NUM_LINES];

  logic [IDX_W-1:0]  req_idx, snp_idx;
  logic [TAG_W-1:0]  req_tag, snp_tag;
  logic              snp_match, fill_snp, lookup_hit;
  logic [1:0]        vic_state;

  assign req_idx = req_addr_q[IDX_W-1:0];
  assign req_tag = req_addr_q[ADDR_W-1:IDX_W];
  assign snp_idx = snoop_addr[IDX_W-1:0];
  assign snp_tag = snoop_addr[ADDR_W-1:IDX_W];

  // A snoop hitting the indexed line in LOOKUP kills it before the compare,
  // so the access misses and a dirty copy is dropped rather than written back.
  assign snp_match  = snoop_inv && (lst_q[snp_idx] != L_I) && (tag_q[snp_idx] == snp_tag);
  assign vic_state  = (snp_match && (snp_idx == req_idx)) ? L_I : lst_q[req_idx];
  assign lookup_hit = (vic_state != L_I) && (tag_q[req_idx] == req_tag);
  assign fill_snp   = snoop_inv && (snoop_addr == req_addr_q);

  // State, request latch, line arrays and counters
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      req_addr_q   <= '0;
      req_we_q     <= 1'b0;
      req_wdata_q  <= '0;
      rdata_q      <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
      for (int i = 0; i < NUM_LINES; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
        lst_q[i]  <= L_I;
      end
    end else begin
      state_q      <= state_d;
      req_addr_q   <= req_addr_d;
      req_we_q     <= req_we_d;
      req_wdata_q  <= req_wdata_d;
      rdata_q      <= rdata_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      for (int i = 0; i < NUM_LINES; i++) begin
        tag_q[i]  <= tag_d[i];
        data_q[i] <= data_d[i];
        lst_q[i]  <= lst_d[i];
      end
    end
  end

  // Next-state, line updates and counters; snoop applies first so that
  // installs in the same cycle (store miss, fill) take precedence
  always_comb begin
    state_d      = state_q;
    req_addr_d   = req_addr_q;
    req_we_d     = req_we_q;
    req_wdata_d  = req_wdata_q;
    rdata_d      = rdata_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    tag_d        = tag_q;
    data_d       = data_q;
    lst_d        = lst_q;

    if (snp_match) lst_d[snp_idx] = L_I;

    case (state_q)
      S_IDLE: begin
        if (cpu_req_valid) begin
          req_addr_d  = cpu_addr;
          req_we_d    = cpu_we;
          req_wdata_d = cpu_wdata;
          state_d     = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (lookup_hit) begin
          if (hit_count_q != 16'hFFFF) hit_count_d = hit_count_q + 16'd1;
          if (req_we_q) begin
            data_d[req_idx] = req_wdata_q;
            lst_d[req_idx]  = L_M;
          end else begin
            rdata_d = data_q[req_idx];
          end
          state_d = S_RESP;
        end else begin
          if (miss_count_q != 16'hFFFF) miss_count_d = miss_count_q + 16'd1;
          if (vic_state == L_M) begin
            state_d = S_WB;
          end else if (req_we_q) begin
            tag_d[req_idx]  = req_tag;
            data_d[req_idx] = req_wdata_q;
            lst_d[req_idx]  = L_M;
            state_d         = S_RESP;
          end else begin
            state_d = S_FILL;
          end
        end
      end
      S_WB: begin
        if (processor_resp) begin
          lst_d[req_idx] = L_I;
          if (req_we_q) begin
            tag_d[req_idx]  = req_tag;
            data_d[req_idx] = req_wdata_q;
            lst_d[req_idx]  = L_M;
            state_d         = S_RESP;
          end else begin
            state_d = S_GAP;
          end
        end
      end
      S_GAP: state_d = S_FILL;
      S_FILL: begin
        if (processor_resp) begin
          tag_d[req_idx]  = req_tag;
          data_d[req_idx] = mem_read_data;
          lst_d[req_idx]  = fill_snp ? L_I : L_S;
          rdata_d         = mem_read_data;
          state_d         = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Memory-side and CPU-side outputs decoded from the current state
  always_comb begin
    processor_req  = 1'b0;
    mem_read_req   = 1'b0;
    mem_write_req  = 1'b0;
    addr           = '0;
    mem_write_data = '0;
    case (state_q)
      S_WB: begin
        processor_req  = 1'b1;
        mem_write_req  = 1'b1;
        addr           = {tag_q[req_idx], req_idx};
        mem_write_data = data_q[req_idx];
      end
      S_FILL: begin
        processor_req = 1'b1;
        mem_read_req  = 1'b1;
        addr          = req_addr_q;
      end
      default: ;
    endcase
  end

  assign cpu_req_ready  = reset_n && (state_q == S_IDLE);
  assign cpu_resp_valid = (state_q == S_RESP);
  assign cpu_rdata      = rdata_q;
  assign hit_count      = hit_count_q;
  assign miss_count     = miss_count_q;

endmodule

// File: tb/tb_l1_cache_ctrl.sv
// Directed bench for l1_cache_ctrl: a table of CPU accesses with hand-computed
// latency, memory traffic, load data and counter values, followed by a
// reset-during-writeback sequence. Memory returns mem[a] = a+1.
module tb_l1_cache_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_req_valid;
  logic        cpu_req_ready;
  logic        cpu_we;
  logic [13:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_resp_valid;
  logic        processor_req;
  logic        mem_read_req;
  logic        mem_write_req;
  logic [13:0] addr;
  logic [15:0] mem_write_data;
  logic [15:0] mem_read_data;
  logic        processor_resp;
  logic        snoop_inv;
  logic [13:0] snoop_addr;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  l1_cache_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_resp_valid(cpu_resp_valid),
    .processor_req(processor_req), .mem_read_req(mem_read_req),
    .mem_write_req(mem_write_req), .addr(addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .processor_resp(processor_resp), .snoop_inv(snoop_inv),
    .snoop_addr(snoop_addr), .hit_count(hit_count), .miss_count(miss_count)
  );

  // snp: 0 none, 1 snoop in IDLE before the request, 2 snoop in LOOKUP,
  //      3 snoop on the fill's processor_resp cycle (all with snoop_addr = a)
  typedef struct {
    logic        we;
    logic [13:0] a;
    logic [15:0] wd;
    int          dly;
    int          snp;
    logic [15:0] exp_rd;
    int          exp_lat;
    int          exp_wb;
    logic [13:0] exp_wb_a;
    logic [15:0] exp_wb_d;
    int          exp_fill;
    logic [13:0] exp_fill_a;
    int          exp_gap;
    int          exp_h;
    int          exp_m;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [13:0] a, input logic [15:0] wd,
                              input int dly, input int snp, input logic [15:0] rd, input int lat,
                              input int wb, input logic [13:0] wba, input logic [15:0] wbd,
                              input int fill, input logic [13:0] fa, input int gap,
                              input int h, input int m);
    vec_t t;
    t.we = we; t.a = a; t.wd = wd; t.dly = dly; t.snp = snp;
    t.exp_rd = rd; t.exp_lat = lat; t.exp_wb = wb; t.exp_wb_a = wba; t.exp_wb_d = wbd;
    t.exp_fill = fill; t.exp_fill_a = fa; t.exp_gap = gap; t.exp_h = h; t.exp_m = m;
    return t;
  endfunction

  task automatic run_vec(input string nm, input vec_t t);
    int          lat = 0;
    logic [15:0] rd = '0;
    int          done = 0;
    int          nwb = 0, nfill = 0, ntx = 0, gap = -1, low_run = 0, k = 0;
    logic [13:0] wb_a = '0, fill_a = '0, cap_a = '0;
    logic [15:0] wb_d = '0, cap_d = '0;
    logic        cap_rd = 1'b0, prev_req = 1'b0;
    logic        proto_bad = 1'b0, ready_bad = 1'b0;

    if (t.snp == 1) begin
      @(negedge clk);
      snoop_inv = 1'b1; snoop_addr = t.a;
      @(posedge clk);
    end
    @(negedge clk);
    snoop_inv = 1'b0;
    chk({nm, " ready_idle"}, cpu_req_ready, 1'b1);
    cpu_req_valid = 1'b1; cpu_we = t.we; cpu_addr = t.a; cpu_wdata = t.wd;
    @(posedge clk);
    for (int c = 0; c < 200 && done == 0; c++) begin
      @(negedge clk);
      cpu_req_valid = 1'b0; processor_resp = 1'b0; snoop_inv = 1'b0; mem_read_data = '0;
      if (c == 0 && t.snp == 2) begin
        snoop_inv = 1'b1; snoop_addr = t.a;
      end
      if (cpu_req_ready) ready_bad = 1'b1;
      if (processor_req) begin
        if (!prev_req) begin
          if (ntx > 0) gap = low_run;
          ntx++; k = 0; low_run = 0;
          cap_a = addr; cap_d = mem_write_data; cap_rd = mem_read_req;
          if (mem_write_req) begin nwb++; wb_a = addr; wb_d = mem_write_data; end
          else begin nfill++; fill_a = addr; end
        end
        if (mem_read_req == mem_write_req || addr != cap_a || mem_read_req != cap_rd ||
            (mem_write_req && mem_write_data != cap_d)) proto_bad = 1'b1;
        k++;
        if (k == t.dly) begin
          processor_resp = 1'b1;
          if (mem_read_req) begin
            mem_read_data = addr + 14'd1;
            if (t.snp == 3) begin snoop_inv = 1'b1; snoop_addr = t.a; end
          end
        end
      end else begin
        low_run++;
        if (mem_read_req || mem_write_req) proto_bad = 1'b1;
      end
      prev_req = processor_req;
      if (cpu_resp_valid) begin
        lat = c + 1; rd = cpu_rdata; done = 1;
      end else begin
        @(posedge clk);
      end
    end
    chk({nm, " completed"}, done, 1);
    chk({nm, " latency"}, lat, t.exp_lat);
    if (!t.we) chk({nm, " rdata"}, rd, t.exp_rd);
    chk({nm, " wb_count"}, nwb, t.exp_wb);
    if (t.exp_wb != 0) begin
      chk({nm, " wb_addr"}, wb_a, t.exp_wb_a);
      chk({nm, " wb_data"}, wb_d, t.exp_wb_d);
    end
    chk({nm, " fill_count"}, nfill, t.exp_fill);
    if (t.exp_fill != 0) chk({nm, " fill_addr"}, fill_a, t.exp_fill_a);
    if (t.exp_wb != 0 && t.exp_fill != 0) chk({nm, " gap"}, gap, t.exp_gap);
    chk({nm, " protocol"}, proto_bad, 1'b0);
    chk({nm, " ready_busy"}, ready_bad, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk({nm, " resp_single"}, cpu_resp_valid, 1'b0);
    chk({nm, " ready_after"}, cpu_req_ready, 1'b1);
    chk({nm, " hit_count"}, hit_count, t.exp_h);
    chk({nm, " miss_count"}, miss_count, t.exp_m);
  endtask

  initial begin
    reset_n = 1'b0; cpu_req_valid = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_read_data = '0; processor_resp = 1'b0; snoop_inv = 1'b0; snoop_addr = '0;

    //         we  a        wd        d  s  rd       lat wb wba   wbd       f  fa       g  h  m
    vecs.push_back(mk(0, 14'h5, 16'h0,    1, 0, 16'h6,    3, 0, 14'h0, 16'h0,    1, 14'h5, 0, 0, 1));
    vecs.push_back(mk(0, 14'h5, 16'h0,    1, 0, 16'h6,    2, 0, 14'h0, 16'h0,    0, 14'h0, 0, 1, 1));
    vecs.push_back(mk(1, 14'h5, 16'hBEEF, 1, 0, 16'h0,    2, 0, 14'h0, 16'h0,    0, 14'h0, 0, 2, 1));
    vecs.push_back(mk(0, 14'h9, 16'h0,    1, 0, 16'hA,    5, 1, 14'h5, 16'hBEEF, 1, 14'h9, 1, 2, 2));
    vecs.push_back(mk(1, 14'h2, 16'h1234, 1, 0, 16'h0,    2, 0, 14'h0, 16'h0,    0, 14'h0, 0, 2, 3));
    vecs.push_back(mk(0, 14'h2, 16'h0,    1, 0, 16'h1234, 2, 0, 14'h0, 16'h0,    0, 14'h0, 0, 3, 3));
    vecs.push_back(mk(0, 14'h3, 16'h0,    1, 0, 16'h4,    3, 0, 14'h0, 16'h0,    1, 14'h3, 0, 3, 4));
    vecs.push_back(mk(0, 14'h3, 16'h0,    1, 1, 16'h4,    3, 0, 14'h0, 16'h0,    1, 14'h3, 0, 3, 5));
    vecs.push_back(mk(0, 14'h7, 16'h0,    5, 0, 16'h8,    7, 0, 14'h0, 16'h0,    1, 14'h7, 0, 3, 6));
    vecs.push_back(mk(1, 14'h6, 16'h5555, 1, 0, 16'h0,    3, 1, 14'h2, 16'h1234, 0, 14'h0, 0, 3, 7));
    vecs.push_back(mk(0, 14'h6, 16'h0,    1, 0, 16'h5555, 2, 0, 14'h0, 16'h0,    0, 14'h0, 0, 4, 7));
    vecs.push_back(mk(0, 14'h6, 16'h0,    1, 1, 16'h7,    3, 0, 14'h0, 16'h0,    1, 14'h6, 0, 4, 8));
    vecs.push_back(mk(0, 14'h9, 16'h0,    1, 2, 16'hA,    3, 0, 14'h0, 16'h0,    1, 14'h9, 0, 4, 9));
    vecs.push_back(mk(0, 14'hD, 16'h0,    1, 3, 16'hE,    3, 0, 14'h0, 16'h0,    1, 14'hD, 0, 4, 10));
    vecs.push_back(mk(0, 14'hD, 16'h0,    1, 0, 16'hE,    3, 0, 14'h0, 16'h0,    1, 14'hD, 0, 4, 11));
    vecs.push_back(mk(0, 14'hD, 16'h0,    1, 0, 16'hE,    2, 0, 14'h0, 16'h0,    0, 14'h0, 0, 5, 11));
    vecs.push_back(mk(1, 14'h5, 16'hBEEF, 1, 0, 16'h0,    2, 0, 14'h0, 16'h0,    0, 14'h0, 0, 5, 12));

    // Reset state, including ready held low while reset_n is asserted
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst ready_low", cpu_req_ready, 1'b0);
    chk("rst preq", processor_req, 1'b0);
    chk("rst resp", cpu_resp_valid, 1'b0);
    reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst ready", cpu_req_ready, 1'b1);
    chk("rst rdata", cpu_rdata, 16'h0);
    chk("rst addr", addr, 14'h0);
    chk("rst hits", hit_count, 16'h0);
    chk("rst misses", miss_count, 16'h0);

    foreach (vecs[i]) run_vec($sformatf("v%0d", i), vecs[i]);

    // Reset during a writeback that memory never acknowledges
    @(negedge clk);
    cpu_req_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h9; cpu_wdata = '0;
    @(posedge clk);
    @(negedge clk);
    cpu_req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("midwb preq", processor_req, 1'b1);
    chk("midwb write", mem_write_req, 1'b1);
    chk("midwb addr", addr, 14'h5);
    chk("midwb data", mem_write_data, 16'hBEEF);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("wbrst ready", cpu_req_ready, 1'b0);
    chk("wbrst preq", processor_req, 1'b0);
    chk("wbrst wreq", mem_write_req, 1'b0);
    chk("wbrst rreq", mem_read_req, 1'b0);
    chk("wbrst addr", addr, 14'h0);
    chk("wbrst wdata", mem_write_data, 16'h0);
    chk("wbrst resp", cpu_resp_valid, 1'b0);
    chk("wbrst rdata", cpu_rdata, 16'h0);
    chk("wbrst hits", hit_count, 16'h0);
    chk("wbrst misses", miss_count, 16'h0);
    reset_n = 1'b1;
    processor_resp = 1'b1; mem_read_data = 16'h7777;
    @(posedge clk);
    @(negedge clk);
    processor_resp = 1'b0; mem_read_data = '0;
    chk("late_resp resp", cpu_resp_valid, 1'b0);
    chk("late_resp ready", cpu_req_ready, 1'b1);
    chk("late_resp preq", processor_req, 1'b0);
    run_vec("post_rst", mk(0, 14'h5, 16'h0, 1, 0, 16'h6, 3, 0, 14'h0, 16'h0, 1, 14'h5, 0, 0, 1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
